// File: rtl/mips_fetch_unit.sv
// Instruction fetch sequencer: holds the PC, fetches words over a req/ready handshake,
// presents each instruction to Control and resolves the next PC from branch/jump decisions.
module mips_fetch_unit #(
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]       HALT_OP  = 6'b111111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    input  logic              instr_accept,
    input  logic              Branch,
    input  logic              jump,
    input  logic              zero,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic              r_req;
    logic              r_halted;

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_is_halt;
    logic              w_fetch_done;
    logic              w_retire;

    assign w_is_halt    = (r_instr[31:26] == HALT_OP);
    assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
    assign w_retire     = (r_state == S_ISSUE) && instr_accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (run)          w_state_nxt = S_FETCH;
            S_FETCH: if (imem_ready)   w_state_nxt = S_ISSUE;
            S_ISSUE: if (instr_accept) w_state_nxt = w_is_halt ? S_HALT : S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next-PC selection; jump outranks a taken branch, all arithmetic wraps
    always_comb begin
        w_pc4      = r_pc + ADDR_W'(4);
        w_br_off   = ADDR_W'($signed({r_instr[15:0], 2'b00}));
        w_jump_tgt = {w_pc4[ADDR_W-1:28], r_instr[25:0], 2'b00};
        w_pc_nxt   = w_pc4;
        if (jump) begin
            w_pc_nxt = w_jump_tgt;
        end else if (Branch && zero) begin
            w_pc_nxt = w_pc4 + w_br_off;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_req    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_req    <= (w_state_nxt == S_FETCH);
            r_halted <= (w_state_nxt == S_HALT);
            if (w_fetch_done) begin
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_retire) begin
                r_valid <= 1'b0;
                if (!w_is_halt) begin
                    r_pc <= w_pc_nxt;
                end
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: small instruction ROM, hand-computed PC and handshake checks.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_accept;
    logic        Branch;
    logic        jump;
    logic        zero;
    logic [31:0] pc;
    logic        halted;

    int n_chk;
    int n_pass;

    mips_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .Branch       (Branch),
        .jump         (jump),
        .zero         (zero),
        .pc           (pc),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image
    always_comb begin
        case (imem_addr)
            32'h0000_0000: imem_rdata = 32'h2008_0005;
            32'h0000_0010: imem_rdata = 32'h1109_FFFF;
            32'h0000_0014: imem_rdata = 32'h0800_0008;
            32'h0000_0020: imem_rdata = 32'h0800_0040;
            32'h0000_0100: imem_rdata = 32'h012A_4020;
            32'h0000_0104: imem_rdata = 32'hFC00_0000;
            default:       imem_rdata = 32'h0000_0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 16 && instr_valid !== 1'b1; i++) step();
        chk("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic retire(input logic br, input logic jmp, input logic z);
        wait_valid();
        Branch       = br;
        jump         = jmp;
        zero         = z;
        instr_accept = 1'b1;
        step();
        instr_accept = 1'b0;
        Branch       = 1'b0;
        jump         = 1'b0;
        zero         = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        run = 1'b0;
        imem_ready = 1'b0;
        instr_accept = 1'b0;
        Branch = 1'b0;
        jump = 1'b0;
        zero = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", instr, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        run = 1'b1;
        imem_ready = 1'b1;

        // Basic fetch and sequential PC
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_valid_early", 32'(instr_valid), 32'd0);
        step();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_opcode", 32'(opcode), 32'd8);
        chk("t1_instr", instr, 32'h2008_0005);
        chk("t1_req_issue", 32'(imem_req), 32'd0);
        run = 1'b0;
        retire(1'b0, 1'b0, 1'b0);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_next_req", 32'(imem_req), 32'd1);
        chk("t1_valid_drop", 32'(instr_valid), 32'd0);
        retire(1'b0, 1'b0, 1'b0);
        retire(1'b0, 1'b0, 1'b0);
        retire(1'b0, 1'b0, 1'b0);
        chk("t1_pc_0x10", pc, 32'h10);

        // Branch taken (offset -1 word) then not taken
        retire(1'b1, 1'b0, 1'b1);
        chk("t2_beq_taken", pc, 32'h10);
        retire(1'b1, 1'b0, 1'b0);
        chk("t2_beq_not_taken", pc, 32'h14);

        // Jumps; jump outranks a taken branch
        retire(1'b0, 1'b1, 1'b0);
        chk("t3_j_0x20", pc, 32'h20);
        retire(1'b1, 1'b1, 1'b1);
        chk("t3_jump_wins", pc, 32'h100);

        // Memory stall then accept stall
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stall_req", 32'(imem_req), 32'd1);
            chk("t4_stall_addr", imem_addr, 32'h100);
            chk("t4_stall_valid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        step();
        chk("t4_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_instr", instr, 32'h012A_4020);
            chk("t4_hold_opcode", 32'(opcode), 32'd0);
            chk("t4_hold_pc", pc, 32'h100);
            chk("t4_hold_valid", 32'(instr_valid), 32'd1);
        end
        retire(1'b0, 1'b0, 1'b0);
        chk("t4_pc_0x104", pc, 32'h104);

        // Halt: pc frozen, no further requests, run ignored
        wait_valid();
        chk("t5_halt_opcode", 32'(opcode), 32'h3F);
        retire(1'b0, 1'b1, 1'b0);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_pc_frozen", pc, 32'h104);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_halt_req", 32'(imem_req), 32'd0);
        end
        chk("t5_still_halted", 32'(halted), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pc", pc, 32'h0);
        chk("t5_rst_halted", 32'(halted), 32'd0);
        step();
        rst_n = 1'b1;

        // Async reset in the middle of a stalled fetch
        imem_ready = 1'b0;
        step();
        step();
        chk("t6_req_before", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(imem_req), 32'd0);
        chk("t6_pc_async", pc, 32'h0);
        chk("t6_valid_async", 32'(instr_valid), 32'd0);
        step();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
